// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router: buffers payload bytes and sends header, payload, parity.
// Optional ROUTER_TX_ERR_INJ_EN adds inj_err_i, which inverts the transmitted parity byte.
module router_pkt_tx (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       wr_en_i,
  input  logic [7:0] wr_data_i,
  output logic [6:0] buf_count_o,
  input  logic       start_i,
  input  logic [1:0] dest_i,
  input  logic [5:0] len_i,
  input  logic       busy_i,
`ifdef ROUTER_TX_ERR_INJ_EN
  input  logic       inj_err_i,
`endif
  output logic [7:0] data_out_o,
  output logic       packet_valid_o,
  output logic       tx_active_o,
  output logic       done_o,
  output logic       start_err_o
);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PARITY} state_e;

  state_e     state_q;
  logic [7:0] mem_q [64];
  logic [5:0] wptr_q, rptr_q, remain_q;
  logic [6:0] count_q;
  logic [7:0] data_q, parity_q;
  logic       pv_q, tx_q, done_q, serr_q;

  logic       wr_fire_d, start_ok_d, accept_d, flip_d;
  logic [7:0] hdr_d, next_byte_d, parity_d;

`ifdef ROUTER_TX_ERR_INJ_EN
  logic inj_q;
  assign flip_d = inj_q;
`else
  assign flip_d = 1'b0;
`endif

  assign wr_fire_d   = (state_q == IDLE) && wr_en_i && !count_q[6] && !reset_i;
  assign start_ok_d  = (dest_i != 2'd3) && (len_i != 6'd0) && ({1'b0, len_i} <= count_q);
  assign accept_d    = !busy_i;
  assign hdr_d       = {len_i, dest_i};
  assign next_byte_d = mem_q[rptr_q + 6'd1];
  // Running parity already holds the header and all earlier payload bytes.
  assign parity_d    = parity_q ^ data_q;

  always_ff @(posedge clk_i) begin
    if (wr_fire_d) mem_q[wptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      remain_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      parity_q <= '0;
      pv_q     <= 1'b0;
      tx_q     <= 1'b0;
      done_q   <= 1'b0;
      serr_q   <= 1'b0;
`ifdef ROUTER_TX_ERR_INJ_EN
      inj_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      serr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_fire_d) begin
            wptr_q  <= wptr_q + 6'd1;
            count_q <= count_q + 7'd1;
          end
          if (start_i) begin
            if (start_ok_d) begin
              state_q  <= HEADER;
              data_q   <= hdr_d;
              parity_q <= hdr_d;
              remain_q <= len_i;
              pv_q     <= 1'b1;
              tx_q     <= 1'b1;
`ifdef ROUTER_TX_ERR_INJ_EN
              inj_q    <= inj_err_i;
`endif
            end else begin
              serr_q <= 1'b1;
            end
          end
        end
        HEADER: begin
          if (accept_d) begin
            state_q <= PAYLOAD;
            data_q  <= mem_q[rptr_q];
          end
        end
        PAYLOAD: begin
          if (accept_d) begin
            rptr_q   <= rptr_q + 6'd1;
            count_q  <= count_q - 7'd1;
            remain_q <= remain_q - 6'd1;
            parity_q <= parity_d;
            if (remain_q == 6'd1) begin
              state_q <= PARITY;
              pv_q    <= 1'b0;
              data_q  <= parity_d ^ {8{flip_d}};
            end else begin
              data_q <= next_byte_d;
            end
          end
        end
        PARITY: begin
          if (accept_d) begin
            state_q <= IDLE;
            tx_q    <= 1'b0;
            done_q  <= 1'b1;
            data_q  <= 8'h00;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign buf_count_o    = count_q;
  assign data_out_o     = data_q;
  assign packet_valid_o = pv_q;
  assign tx_active_o    = tx_q;
  assign done_o         = done_q;
  assign start_err_o    = serr_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: directed literal scenarios plus randomized traffic against a frame-queue model.
// Define ROUTER_TX_ERR_INJ_EN to also exercise the parity inversion feature.
module tb_router_pkt_tx;

  logic       clk = 1'b0;
  logic       reset_i, wr_en_i, start_i, busy_i;
  logic [7:0] wr_data_i;
  logic [1:0] dest_i;
  logic [5:0] len_i;
  logic [6:0] buf_count_o;
  logic [7:0] data_out_o;
  logic       packet_valid_o, tx_active_o, done_o, start_err_o;
`ifdef ROUTER_TX_ERR_INJ_EN
  logic       inj_err_i;
`endif

  int total = 0;
  int bad = 0;

  router_pkt_tx dut (
    .clk_i(clk), .reset_i(reset_i), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
    .buf_count_o(buf_count_o), .start_i(start_i), .dest_i(dest_i), .len_i(len_i),
    .busy_i(busy_i),
`ifdef ROUTER_TX_ERR_INJ_EN
    .inj_err_i(inj_err_i),
`endif
    .data_out_o(data_out_o), .packet_valid_o(packet_valid_o), .tx_active_o(tx_active_o),
    .done_o(done_o), .start_err_o(start_err_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: buffer contents as a byte queue and the packet still to be presented as a frame queue.
  logic [7:0] modelBuf[$];
  logic [7:0] modelFrame[$];
  int         modelKind[$];
  logic       modelOn = 1'b0;
  logic       expDone = 1'b0;
  logic       expErr = 1'b0;

  always @(posedge clk) begin
    logic [7:0] p;
    logic       inj;
    int         k;
    if (reset_i) begin
      modelBuf.delete();
      modelFrame.delete();
      modelKind.delete();
      expDone = 1'b0;
      expErr  = 1'b0;
      modelOn = 1'b1;
    end else begin
      expDone = 1'b0;
      expErr  = 1'b0;
      if (modelFrame.size() != 0) begin
        if (!busy_i) begin
          k = modelKind.pop_front();
          void'(modelFrame.pop_front());
          if (k == 1) void'(modelBuf.pop_front());
          if (k == 2) expDone = 1'b1;
        end
      end else begin
        if (start_i) begin
          if (dest_i != 2'd3 && len_i != 6'd0 && int'(len_i) <= modelBuf.size()) begin
            p = {len_i, dest_i};
            modelFrame.push_back(p);
            modelKind.push_back(0);
            for (int i = 0; i < int'(len_i); i++) begin
              p = p ^ modelBuf[i];
              modelFrame.push_back(modelBuf[i]);
              modelKind.push_back(1);
            end
`ifdef ROUTER_TX_ERR_INJ_EN
            inj = inj_err_i;
`else
            inj = 1'b0;
`endif
            modelFrame.push_back(inj ? ~p : p);
            modelKind.push_back(2);
          end else begin
            expErr = 1'b1;
          end
        end
        if (wr_en_i && modelBuf.size() < 64) modelBuf.push_back(wr_data_i);
      end
    end
  end

  always @(negedge clk) begin
    if (modelOn) begin
      checkOutput("m_data", data_out_o, (modelFrame.size() != 0) ? modelFrame[0] : 8'h00);
      checkOutput("m_pv", packet_valid_o, modelFrame.size() > 1);
      checkOutput("m_tx", tx_active_o, modelFrame.size() != 0);
      checkOutput("m_done", done_o, expDone);
      checkOutput("m_serr", start_err_o, expErr);
      checkOutput("m_count", buf_count_o, modelBuf.size());
    end
  end

  // Inputs change on the falling edge; each call spans one clock.
  task automatic applyStimulus(input logic rst, input logic w, input logic [7:0] d, input logic s,
                               input logic [1:0] de, input logic [5:0] l, input logic b,
                               input logic inj);
    reset_i   = rst;
    wr_en_i   = w;
    wr_data_i = d;
    start_i   = s;
    dest_i    = de;
    len_i     = l;
    busy_i    = b;
`ifdef ROUTER_TX_ERR_INJ_EN
    inj_err_i = inj;
`else
    if (inj) begin end
`endif
    @(negedge clk);
  endtask

  task automatic idle(input logic b);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 6'd0, b, 1'b0);
  endtask

  task automatic writeByte(input logic [7:0] d);
    applyStimulus(1'b0, 1'b1, d, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0);
  endtask

  logic [7:0] captured[$];

  task automatic runPacket(input logic [1:0] de, input logic [5:0] l, input logic inj);
    logic seen;
    captured.delete();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, de, l, 1'b0, inj);
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      if (done_o) seen = 1'b1;
      else begin
        if (tx_active_o) captured.push_back(data_out_o);
        idle(1'b0);
      end
    end
    checkOutput("pkt_done", seen, 1'b1);
  endtask

  logic [7:0] basicExp [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
  logic [7:0] stallExp [8] = '{8'h0D, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'h33, 8'h0D};
  logic       stallBusy [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    reset_i = 1'b1; wr_en_i = 1'b0; wr_data_i = 8'h00; start_i = 1'b0;
    dest_i = 2'd0; len_i = 6'd0; busy_i = 1'b0;
`ifdef ROUTER_TX_ERR_INJ_EN
    inj_err_i = 1'b0;
`endif
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0);
    checkOutput("rst_data", data_out_o, 8'h00);
    checkOutput("rst_pv", packet_valid_o, 1'b0);
    checkOutput("rst_tx", tx_active_o, 1'b0);
    checkOutput("rst_count", buf_count_o, 7'd0);

    $display("[TB] basic packet");
    writeByte(8'h11); writeByte(8'h22); writeByte(8'h33);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 2'd1, 6'd3, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("basic_byte", data_out_o, basicExp[i]);
      checkOutput("basic_pv", packet_valid_o, i < 4);
      idle(1'b0);
    end
    checkOutput("basic_done", done_o, 1'b1);
    checkOutput("basic_count", buf_count_o, 7'd0);

    $display("[TB] busy stall");
    writeByte(8'h11); writeByte(8'h22); writeByte(8'h33);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 2'd1, 6'd3, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("stall_byte", data_out_o, stallExp[i]);
      checkOutput("stall_pv", packet_valid_o, i < 7);
      idle(stallBusy[i]);
    end
    checkOutput("stall_done", done_o, 1'b1);

`ifdef ROUTER_TX_ERR_INJ_EN
    $display("[TB] parity injection");
    writeByte(8'h11); writeByte(8'h22); writeByte(8'h33);
    runPacket(2'd1, 6'd3, 1'b1);
    checkOutput("inj_size", captured.size(), 5);
    for (int i = 0; i < 4; i++) checkOutput("inj_byte", captured[i], basicExp[i]);
    checkOutput("inj_parity", captured[4], 8'hF2);
`endif

    $display("[TB] start rejection");
    writeByte(8'hAA); writeByte(8'hBB);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 2'd3, 6'd1, 1'b0, 1'b0);
    checkOutput("rej_dest", start_err_o, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 6'd0, 1'b0, 1'b0);
    checkOutput("rej_len0", start_err_o, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 6'd5, 1'b0, 1'b0);
    checkOutput("rej_short", start_err_o, 1'b1);
    checkOutput("rej_tx", tx_active_o, 1'b0);
    checkOutput("rej_count", buf_count_o, 7'd2);
    runPacket(2'd2, 6'd2, 1'b0);

    $display("[TB] reset mid-packet");
    writeByte(8'h11); writeByte(8'h22); writeByte(8'h33);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 2'd1, 6'd3, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    checkOutput("mid_second", data_out_o, 8'h22);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0);
    checkOutput("mid_pv", packet_valid_o, 1'b0);
    checkOutput("mid_data", data_out_o, 8'h00);
    checkOutput("mid_count", buf_count_o, 7'd0);
    idle(1'b0);
    checkOutput("mid_nodone", done_o, 1'b0);

    $display("[TB] wrap-around");
    for (int i = 0; i < 60; i++) writeByte(8'(i));
    runPacket(2'd0, 6'd60, 1'b0);
    for (int i = 0; i < 10; i++) writeByte(8'hA0 + 8'(i));
    runPacket(2'd0, 6'd10, 1'b0);
    checkOutput("wrap_size", captured.size(), 12);
    checkOutput("wrap_hdr", captured[0], 8'h28);
    for (int i = 0; i < 10; i++) checkOutput("wrap_byte", captured[1 + i], 8'hA0 + 8'(i));
    checkOutput("wrap_parity", captured[11], 8'h29);

    $display("[TB] random traffic");
    for (int c = 0; c < 2000; c++) begin
      applyStimulus($urandom_range(0, 299) == 0, 1'($urandom), 8'($urandom),
                    $urandom_range(0, 7) == 0,
                    ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                    ($urandom_range(0, 15) == 0) ? 6'd0 : 6'($urandom_range(1, 20)),
                    $urandom_range(0, 2) == 0, 1'($urandom));
    end
    idle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet source for the 1x3 router: buffers payload bytes, then transmits one framed packet (header, payload, parity) into the router's input port using the router's `packet_valid` / `busy` protocol. Sits upstream of the router top level, generating the byte stream that the router's register and FSM blocks consume and parity-check. Used as the on-chip traffic source and as the stimulus driver in router-level benches.

## Interface

- No parameters. Buffer depth fixed at 64 bytes. Maximum payload is 63 bytes.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  payload buffer write strobe.
- `wr_data`  in  8  payload byte to buffer.
- `buf_count`  out  7  bytes currently buffered, 0..64.
- `start`  in  1  request to send one packet.
- `dest`  in  2  destination port 0..2; sampled with `start`.
- `len`  in  6  payload length 1..63; sampled with `start`.
- `busy`  in  1  router busy; the presented byte is held while this is high.
- `data_out`  out  8  byte presented to the router.
- `packet_valid`  out  1  high while the header and payload bytes are presented.
- `tx_active`  out  1  high from the header through parity acceptance.
- `done`  out  1  one-cycle pulse after the parity byte is accepted.
- `start_err`  out  1  one-cycle pulse when a `start` is rejected.
- `inj_err`  in  1  present only with `ROUTER_TX_ERR_INJ_EN`; see Configuration.

## Operation

- **Payload buffer**
  - 64-entry circular buffer with 6-bit read and write pointers that wrap 63→0.
  - `wr_en` writes only when the FSM is in IDLE and `buf_count` < 64. Otherwise the write is dropped silently.
- **Header byte:** `{len[5:0], dest[1:0]}`.
- **Parity byte:** XOR of the header and all payload bytes.
- **FSM states:** IDLE, HEADER, PAYLOAD, PARITY.
- **IDLE → HEADER** on `start` when all of the following hold:
  - `dest` != 3
  - `len` != 0
  - `len` <= `buf_count`, using the count registered before any same-cycle write.
- **Rejected start:** if any of those conditions fails, the FSM stays in IDLE and `start_err` pulses.
- **`start` outside IDLE** is ignored, with no pulse.
- **Byte acceptance:** a presented byte is accepted at any rising edge where `busy` = 0.
- **HEADER:** on acceptance, go to PAYLOAD and present buffer byte 0.
- **PAYLOAD**
  - Each acceptance pops one buffer byte and presents the next.
  - After byte `len`-1 is accepted, go to PARITY.
- **PARITY**
  - `packet_valid` = 0 and `data_out` = parity byte.
  - On acceptance, go to IDLE and pulse `done`.
- **Leftover bytes:** bytes beyond `len` stay buffered for the next packet. `buf_count` decrements on each payload pop.
- **`busy` held high** stalls indefinitely. No timeout.

## Timing

- **Reset values:**
  - `data_out` = 0x00
  - `packet_valid` = 0, `tx_active` = 0, `done` = 0, `start_err` = 0
  - `buf_count` = 0; pointers = 0; FSM = IDLE
- **Reset mid-packet:**
  - In the cycle after `reset`, all outputs are at reset values and the buffer is emptied.
  - No `done` pulse is produced.
- **Start latency:** `start` accepted at edge N → header on `data_out` and `packet_valid` = 1 from cycle N+1.
- **Hold under stall:** `data_out` changes only in the cycle after an acceptance edge. It is held stable while `busy` = 1.
- **Minimum packet duration:** with `busy` = 0 throughout, the header, `len` payload bytes and the parity byte occupy `len`+2 consecutive cycles. `done` pulses in the following cycle.
- **Output registration:** all outputs are registered. There is no combinational path from `busy` to `data_out`.
- **`start_err` timing:** pulses in cycle N+1 for a start rejected at edge N.
- **Back-to-back packets:** the earliest next `start` is in the cycle `done` is high (FSM is IDLE then).
- **`buf_count` timing:** reflects a write or pop in the cycle after the edge.

## Configuration

- **`ROUTER_TX_ERR_INJ_EN` defined**
  - Adds the `inj_err` input.
  - `inj_err` is captured with an accepted `start`.
  - If captured high, the transmitted parity byte is the bitwise inverse of the computed parity, so the router must flag `err`.
- **`ROUTER_TX_ERR_INJ_EN` undefined:** the port and logic are absent, and parity is always correct.

## Test plan

- **Basic packet:** write 0x11, 0x22, 0x33; `start` with `dest`=1, `len`=3, `busy`=0.
  - Required: `data_out` = 0x0D, 0x11, 0x22, 0x33, 0x0D on consecutive cycles.
  - Required: `packet_valid` = 1,1,1,1,0; `done` pulses one cycle later; `buf_count` = 0.
- **Busy stall:** same packet with `busy`=1 for 3 cycles while 0x22 is presented.
  - Required: 0x22 held for 4 cycles; `packet_valid` stays 1; remaining sequence unchanged.
- **Start rejection:** `start` with `dest`=3; then `len`=0; then `len`=5 with `buf_count`=2.
  - Required: `start_err` pulses three times; `tx_active` stays 0; `buf_count` stays 2.
- **Wrap-around:** write 60 bytes, send `len`=60, then write 10 bytes 0xA0..0xA9, send `len`=10.
  - Required: second packet payload is 0xA0..0xA9 in order.
  - Required: parity = XOR of header 0x28 and the ten payload bytes.
- **Reset mid-packet:** assert `reset` while the 2nd payload byte is presented.
  - Required: next cycle `packet_valid`=0, `data_out`=0x00, `buf_count`=0, no `done`.
- **Error injection (macro defined):** basic packet with `inj_err`=1.
  - Required: parity byte transmitted as 0xF2; all other bytes unchanged.
